// File: rtl/fml_pkg.sv
// fml_pkg -- constants shared by every FML master, slave and arbiter.
//   FML_BEATS    : beats of 32 bits in one FML burst
//   FML_NMASTERS : number of masters an FML arbiter serves
//   fml_mid_t    : master index type for FML_NMASTERS masters
package fml_pkg;

  localparam int FML_BEATS    = 4;
  localparam int FML_NMASTERS = 4;

  typedef logic [$clog2(FML_NMASTERS)-1:0] fml_mid_t;

endpackage

// File: rtl/fml_arb4.sv
// fml_arb4 -- four-master round-robin arbiter in front of one FML slave port.
//
// Ports
//   sys_clk, sys_rst     : clock and synchronous active-high reset
//   mN_adr/stb/we        : master N address-phase request (N = 0..3)
//   mN_sel/di            : master N write byte enables / write data
//   mN_ack, mN_do        : master N acknowledge / read data (s_do broadcast)
//   s_adr/stb/we, s_ack  : slave address phase
//   s_sel/di, s_do       : slave write data path / read data
//
// The address phase follows the grant g; write data follows the burst owner w
// for the three beats after an ack, so the next address phase may overlap the
// tail of the previous write burst.
module fml_arb4
  import fml_pkg::*;
#(
  parameter int fml_depth = 26
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic [fml_depth-1:0] m0_adr,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  output logic                 m0_ack,
  input  logic [3:0]           m0_sel,
  input  logic [31:0]          m0_di,
  output logic [31:0]          m0_do,

  input  logic [fml_depth-1:0] m1_adr,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  output logic                 m1_ack,
  input  logic [3:0]           m1_sel,
  input  logic [31:0]          m1_di,
  output logic [31:0]          m1_do,

  input  logic [fml_depth-1:0] m2_adr,
  input  logic                 m2_stb,
  input  logic                 m2_we,
  output logic                 m2_ack,
  input  logic [3:0]           m2_sel,
  input  logic [31:0]          m2_di,
  output logic [31:0]          m2_do,

  input  logic [fml_depth-1:0] m3_adr,
  input  logic                 m3_stb,
  input  logic                 m3_we,
  output logic                 m3_ack,
  input  logic [3:0]           m3_sel,
  input  logic [31:0]          m3_di,
  output logic [31:0]          m3_do,

  output logic [fml_depth-1:0] s_adr,
  output logic                 s_stb,
  output logic                 s_we,
  input  logic                 s_ack,
  output logic [3:0]           s_sel,
  output logic [31:0]          s_di,
  input  logic [31:0]          s_do
);

  localparam int WCNT_W = $clog2(FML_BEATS);

  // Round-robin pick: first requester scanning cur+1, cur+2, cur+3, cur.
  // With excl_cur set the current master is left out of the scan. If nobody
  // qualifies the current grant is kept.
  function automatic fml_mid_t rr_pick(input logic [FML_NMASTERS-1:0] req,
                                       input fml_mid_t cur,
                                       input logic excl_cur);
    fml_mid_t res;
    fml_mid_t idx;
    logic     found;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= FML_NMASTERS; k++) begin
      idx = cur + fml_mid_t'(k);
      if (!found && req[idx] && !(k == FML_NMASTERS && excl_cur)) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Gather the per-master ports into arrays so the muxes index by master id.
  logic [fml_depth-1:0]    adr [FML_NMASTERS];
  logic [3:0]              sel [FML_NMASTERS];
  logic [31:0]             di  [FML_NMASTERS];
  logic [FML_NMASTERS-1:0] stb;
  logic [FML_NMASTERS-1:0] we;
  logic [FML_NMASTERS-1:0] ack;

  assign adr[0] = m0_adr;  assign adr[1] = m1_adr;
  assign adr[2] = m2_adr;  assign adr[3] = m3_adr;
  assign sel[0] = m0_sel;  assign sel[1] = m1_sel;
  assign sel[2] = m2_sel;  assign sel[3] = m3_sel;
  assign di[0]  = m0_di;   assign di[1]  = m1_di;
  assign di[2]  = m2_di;   assign di[3]  = m3_di;
  assign stb    = {m3_stb, m2_stb, m1_stb, m0_stb};
  assign we     = {m3_we, m2_we, m1_we, m0_we};

  fml_mid_t          g;      // address-phase grant
  fml_mid_t          w;      // owner of the write beats in flight
  logic [WCNT_W-1:0] wcnt;   // write beats still to come after the ack beat
  logic              ack_d;  // s_ack delayed one cycle

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      g     <= '0;
      w     <= '0;
      wcnt  <= '0;
      ack_d <= 1'b0;
    end else begin
      ack_d <= s_ack;
      // A new grant taken on the ack cycle is only visible next cycle,
      // where ack_d already holds s_stb low.
      if (s_ack || !stb[g])
        g <= rr_pick(stb, g, s_ack);
      if (s_ack) begin
        w    <= g;
        wcnt <= WCNT_W'(FML_BEATS - 1);
      end else if (wcnt != '0) begin
        wcnt <= wcnt - WCNT_W'(1);
      end
    end
  end

  // Address phase: purely from registered state and master inputs, so there
  // is no combinational path from s_ack into s_stb.
  assign s_adr = adr[g];
  assign s_we  = we[g];
  assign s_stb = stb[g] & ~ack_d & ~sys_rst;

  // Data phase: beat 0 comes from the acked master, beats 1..3 from w.
  fml_mid_t src;
  logic     sel_en;

  always_comb begin
    src    = g;
    sel_en = 1'b0;
    if (s_ack) begin
      sel_en = 1'b1;
    end else if (wcnt != '0) begin
      src    = w;
      sel_en = 1'b1;
    end
  end

  assign s_di  = di[src];
  assign s_sel = (sel_en && !sys_rst) ? sel[src] : 4'h0;

  generate
    for (genvar gi = 0; gi < FML_NMASTERS; gi++) begin : g_ack
      assign ack[gi] = s_ack & ~sys_rst & (g == fml_mid_t'(gi));
    end
  endgenerate

  assign m0_ack = ack[0];
  assign m1_ack = ack[1];
  assign m2_ack = ack[2];
  assign m3_ack = ack[3];

  // Read data goes to everyone; each master qualifies it with its own ack.
  assign m0_do = s_do;
  assign m1_do = s_do;
  assign m2_do = s_do;
  assign m3_do = s_do;

endmodule

// File: doc/fml_arb4.md
FML_ARB4 -- requirements
Module: fml_arb4

Interface
REQ-001 SHALL have parameter fml_depth, default 26, meaning the FML byte-address width.
REQ-002 SHALL have port sys_clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have, for each master n in 0..3, port mn_adr, input, fml_depth bits: burst address.
REQ-005 SHALL have, per master, ports mn_stb (input, 1), mn_we (input, 1), mn_ack (output, 1): request, direction, acknowledge.
REQ-006 SHALL have, per master, ports mn_sel (input, 4), mn_di (input, 32), mn_do (output, 32): write byte enables, write data, read data.
REQ-007 SHALL have slave-side ports s_adr (output, fml_depth), s_stb (output, 1), s_we (output, 1) and s_ack (input, 1), driving the controller FML port.
REQ-008 SHALL have slave-side ports s_sel (output, 4), s_di (output, 32) and s_do (input, 32).

Function
REQ-009 SHALL hold a 2-bit grant register g that selects the address-phase master.
- s_adr = mg_adr; s_we = mg_we; s_stb = mg_stb & ~ack_d.
- ack_d is s_ack registered once.
REQ-010 SHALL route s_ack only to mg_ack; every other mn_ack SHALL be 0 in the same cycle.
REQ-011 SHALL broadcast s_do to all mn_do unmodified; masters qualify read data by their own ack.
REQ-012 SHALL treat a burst as 4 beats of 32 bits. Write beat 0 is the s_ack cycle; beats 1..3 are the next 3 cycles.
REQ-013 SHALL, on the s_ack cycle, drive s_di and s_sel from master g, load owner w <= g, and load beat counter wcnt <= 3.
REQ-014 SHALL, while wcnt != 0, drive s_di and s_sel from master w and decrement wcnt each cycle.
REQ-015 SHALL, when neither REQ-013 nor REQ-014 applies, drive s_di from master g and drive s_sel = 4'h0.
REQ-016 SHALL re-arbitrate when (s_ack = 1) or (mg_stb = 0). The new g is the first n with mn_stb = 1, scanning g+1, g+2, g+3, g (mod 4). On s_ack the current g SHALL be excluded from the scan.
REQ-017 SHALL keep g unchanged when re-arbitration finds no requester.
REQ-018 SHALL keep g stable while mg_stb = 1 and s_ack = 0; no preemption.
REQ-019 SHALL let a new address phase overlap write beats 1..3 of the previous burst: the address mux follows g and the data mux follows w, independently.
REQ-020 SHALL, when s_ack and re-arbitration coincide, apply the new g in the following cycle. During that cycle s_stb is forced 0 by ack_d.
REQ-021 SHALL give a sole requester back-to-back bursts, with at most 1 idle s_stb cycle (the ack_d cycle) between acks.
REQ-022 SHALL add no combinational path from s_ack to s_stb.

Reset
REQ-023 SHALL, while sys_rst = 1 at a clock edge, set g = 0, w = 0, wcnt = 0 and ack_d = 0.
REQ-024 SHALL, during reset, drive all mn_ack = 0, s_stb = 0 and s_sel = 0.
REQ-025 SHALL abandon any in-flight write beats on reset; the controller is reset concurrently by the same sys_rst.

Structure
REQ-026 SHALL be a single module with no sub-modules; the 4-way round-robin picker SHALL be a local function.
REQ-027 SHALL place the constants FML_BEATS = 4 and FML_NMASTERS = 4 in a shared fml package. The package SHALL also be used by other FML masters and slaves.

Verification
REQ-028 Scenario: reset, then m2 alone requests a read at 0x0001000, with s_ack 3 cycles later -> s_adr = 0x0001000, m2_ack pulses once, all other acks stay 0, g = 2.
REQ-029 Scenario: m0..m3 all hold stb, slave acks every 2nd eligible cycle -> grant order 1,2,3,0,1 (starting g = 0, g excluded on ack) and no master is starved.
REQ-030 Scenario: m1 writes with sel = F,3,C,0 and data A0..A3, while m3 requests during beats 1..3 -> s_di/s_sel carry m1 values for all 4 beats, and s_adr switches to m3 during the beats.
REQ-031 Scenario: sys_rst asserted on write beat 2 -> next cycle wcnt = 0, s_sel = 0, s_stb = 0, g = 0.
REQ-032 Scenario: m0 holds stb continuously, with ack on cycles 5 and 8 -> s_stb low only on cycles 6 and 9; m0 acked twice.
REQ-033 Scenario: granted m2 drops stb without ack while m0 requests -> g = 0 next cycle, and m2_ack never asserts.
